uart_cmd_frontend: RTL and testbench



---
 rtl/uart_cmd_frontend.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_frontend.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frontend.sv
// Framed-command UART front-end: key/mode load, length-bounded data bursts, end-of-stream, paced TX.
// Optional ECHO_ACK_EN: completed commands queue an ACK (06), errors a NAK (15), sent ahead of core data.
module uart_cmd_frontend #(
  parameter int         KEY_BYTES = 8,
  parameter int         LEN_W     = 16,
  parameter logic [7:0] CMD_KEY   = 8'h4B,
  parameter logic [7:0] CMD_MODE  = 8'h4D,
  parameter logic [7:0] CMD_DATA  = 8'h44,
  parameter logic [7:0] CMD_END   = 8'h45
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   mode_out,
  output logic                   key_en,
  output logic [7:0]             data_out,
  output logic                   data_en,
  output logic                   stream_end,
  input  logic [7:0]             core_data,
  input  logic                   core_empty,
  output logic                   core_rd,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  output logic                   err_flag
);
  localparam int CW = $clog2(KEY_BYTES + 1);

  typedef enum logic [2:0] {IDLE, KEY, MODE, LEN_HI, LEN_LO, DATA} state_t;

  state_t           state;
  logic [CW-1:0]    key_cnt;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] remaining;
  logic [15:0]      len16;
  logic [LEN_W-1:0] len_full;
  logic             is_cmd;
  logic             key_last;
  logic             cmd_err;

  // For 8-bit lengths len_hi stays zero, so the low slice is just the received byte.
  assign len16    = {len_hi, rx_data};
  assign len_full = len16[LEN_W-1:0];
  assign is_cmd   = (rx_data == CMD_KEY) || (rx_data == CMD_MODE) ||
                    (rx_data == CMD_DATA) || (rx_data == CMD_END);
  assign key_last = (key_cnt == CW'(KEY_BYTES - 1));
  assign cmd_err  = rx_parity_err ||
                    (rx_valid && (state == IDLE) && !is_cmd) ||
                    (rx_valid && (state == LEN_LO) && (len_full == '0));

  assign data_en  = rx_valid && !rx_parity_err && (state == DATA) && !rst;
  assign data_out = data_en ? rx_data : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_out    <= '0;
      mode_out   <= 1'b0;
      key_en     <= 1'b0;
      stream_end <= 1'b0;
      err_flag   <= 1'b0;
      key_cnt    <= '0;
      len_hi     <= 8'h00;
      remaining  <= '0;
    end else begin
      key_en <= 1'b0;
      if (cmd_err) err_flag <= 1'b1;
      if (rx_parity_err) begin
        stream_end <= 1'b1;
        state      <= IDLE;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == CMD_KEY) begin
              key_cnt <= '0;
              state   <= KEY;
            end else if (rx_data == CMD_MODE) begin
              state <= MODE;
            end else if (rx_data == CMD_DATA) begin
              len_hi <= 8'h00;
              state  <= (LEN_W == 8) ? LEN_LO : LEN_HI;
            end else if (rx_data == CMD_END) begin
              stream_end <= 1'b1;
            end
          end
          KEY: begin
            key_out[8*(KEY_BYTES-1-int'(key_cnt)) +: 8] <= rx_data;
            key_cnt <= key_cnt + CW'(1);
            if (key_last) state <= IDLE;
          end
          MODE: begin
            mode_out <= rx_data[0];
            key_en   <= 1'b1;
            state    <= IDLE;
          end
          LEN_HI: begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (len_full == '0) begin
              state <= IDLE;
            end else begin
              remaining <= len_full;
              state     <= DATA;
            end
          end
          DATA: begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // TX staging: one byte in flight, released only after uart_tx has gone busy and idle again.
  logic staged;
  logic rd_pend;
  logic sent;
  logic busy_seen;

`ifdef ECHO_ACK_EN
  logic       ack_vld;
  logic [7:0] ack_byte;
  logic       cmd_done;
  logic       stage_ack;

  assign cmd_done  = rx_valid && !rx_parity_err &&
                     (((state == IDLE) && (rx_data == CMD_END)) ||
                      ((state == KEY) && key_last) ||
                      (state == MODE) ||
                      ((state == DATA) && (remaining == LEN_W'(1))));
  assign stage_ack = !staged && !rd_pend && ack_vld;
  assign core_rd   = !staged && !rd_pend && !ack_vld && !core_empty && !rst;
`else
  assign core_rd   = !staged && !rd_pend && !core_empty && !rst;
`endif

  assign tx_en = staged && !tx_busy && !sent && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      staged    <= 1'b0;
      rd_pend   <= 1'b0;
      sent      <= 1'b0;
      busy_seen <= 1'b0;
      tx_data   <= 8'h00;
`ifdef ECHO_ACK_EN
      ack_vld   <= 1'b0;
      ack_byte  <= 8'h00;
`endif
    end else begin
      rd_pend <= core_rd;
      if (rd_pend) begin
        tx_data <= core_data;
        staged  <= 1'b1;
      end
`ifdef ECHO_ACK_EN
      else if (stage_ack) begin
        tx_data <= ack_byte;
        staged  <= 1'b1;
      end
      if (cmd_done) begin
        ack_vld  <= 1'b1;
        ack_byte <= 8'h06;
      end else if (cmd_err) begin
        ack_vld  <= 1'b1;
        ack_byte <= 8'h15;
      end else if (stage_ack) begin
        ack_vld <= 1'b0;
      end
`endif
      if (tx_en) sent <= 1'b1;
      if (sent && tx_busy) busy_seen <= 1'b1;
      if (sent && busy_seen && !tx_busy) begin
        staged    <= 1'b0;
        sent      <= 1'b0;
        busy_seen <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_frontend.sv
// Bench for uart_cmd_frontend: directed command frames, then random commands against a command-level
// model with a concurrent core/uart_tx responder checking TX ordering and single-byte pacing.
module tb_uart_cmd_frontend;
  localparam int KB = 8;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_parity_err;
  logic [8*KB-1:0] key_out;
  logic          mode_out;
  logic          key_en;
  logic [7:0]    data_out;
  logic          data_en;
  logic          stream_end;
  logic [7:0]    core_data;
  logic          core_empty;
  logic          core_rd;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_busy;
  logic          err_flag;

  uart_cmd_frontend #(.KEY_BYTES(KB), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .key_out(key_out), .mode_out(mode_out),
    .key_en(key_en), .data_out(data_out), .data_en(data_en),
    .stream_end(stream_end), .core_data(core_data), .core_empty(core_empty),
    .core_rd(core_rd), .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] core_q[$];
  logic [7:0] got_tx[$];
  logic [7:0] got_data[$];
  logic [7:0] exp_data[$];
  logic [7:0] exp_tx[$];
  int         key_en_cnt = 0;
  int         busy_cnt = 0;
  bit         outstanding = 0;

  function automatic bit is_core(input logic [7:0] b);
`ifdef ECHO_ACK_EN
    return !(b == 8'h06 || b == 8'h15);
`else
    return 1'b1;
`endif
  endfunction

  // Core FIFO and uart_tx models; outputs sampled mid-cycle, inputs updated just after the edge.
  initial begin
    bit rd_seen, en_seen;
    logic [7:0] en_byte;
    forever begin
      @(negedge clk);
      if (data_en) got_data.push_back(data_out);
      if (key_en) key_en_cnt++;
      if (core_rd) chk_eq("rd_while_inflight", 64'(outstanding), 0);
      if (tx_en) chk_eq("tx_en_while_busy", 64'(tx_busy), 0);
      rd_seen = core_rd;
      en_seen = tx_en;
      en_byte = tx_data;
      if (core_rd || tx_en) outstanding = 1;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        core_data  = core_q.pop_front();
        core_empty = (core_q.size() == 0);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy = 1'b0;
          outstanding = 0;
        end
      end
      if (en_seen) begin
        got_tx.push_back(en_byte);
        tx_busy  = 1'b1;
        busy_cnt = 10;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe);
    rx_data = b;
    rx_valid = 1'b1;
    rx_parity_err = pe;
    step();
    rx_valid = 1'b0;
    rx_parity_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_tx_idle();
    repeat (40) step();
    for (int c = 0; c < 200 && tx_busy; c++) step();
  endtask

  logic [63:0] exp_key;
  logic        exp_mode, exp_err, exp_end;
  int          exp_ken;
  int          ncore;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_parity_err = 1'b0;
    core_data = 8'h00; core_empty = 1'b0; tx_busy = 1'b0;
    step();
    step();
    chk_eq("rst_key", key_out, 0);
    chk_eq("rst_mode", mode_out, 0);
    chk_eq("rst_key_en", key_en, 0);
    chk_eq("rst_data_en", data_en, 0);
    chk_eq("rst_end", stream_end, 0);
    chk_eq("rst_err", err_flag, 0);
    chk_eq("rst_core_rd", core_rd, 0);
    chk_eq("rst_tx_en", tx_en, 0);
    chk_eq("rst_tx_data", tx_data, 0);
    core_empty = 1'b1;
    rst = 1'b0;
    step();

    // Full key load, then mode load with key_en timing.
    key_en_cnt = 0;
    send(8'h4B, 0);
    for (int i = 0; i < KB; i++) send(8'(i * 8'h11), 0);
    chk_eq("key_full", key_out, 64'h0011223344556677);
    chk_eq("key_no_key_en", key_en_cnt, 0);
    send(8'h4D, 0);
    send(8'h01, 0);
    chk_eq("mode_key_en_hi", key_en, 1);
    chk_eq("mode_val", mode_out, 1);
    step();
    chk_eq("mode_key_en_lo", key_en, 0);
    chk_eq("mode_key_en_cnt", key_en_cnt, 1);
    chk_eq("mode_key_kept", key_out, 64'h0011223344556677);

    // Three-byte burst; trailing byte is an unknown header.
    got_data.delete();
    send(8'h44, 0); send(8'h00, 0); send(8'h03, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    chk_eq("burst_no_err", err_flag, 0);
    send(8'hDD, 0);
    chk_eq("burst_cnt", got_data.size(), 3);
    chk_eq("burst_b0", got_data.size() > 0 ? got_data[0] : 8'hxx, 8'hAA);
    chk_eq("burst_b1", got_data.size() > 1 ? got_data[1] : 8'hxx, 8'hBB);
    chk_eq("burst_b2", got_data.size() > 2 ? got_data[2] : 8'hxx, 8'hCC);
    chk_eq("burst_tail_err", err_flag, 1);

    // Parity error mid-burst.
    do_reset();
    got_data.delete();
    send(8'h44, 0); send(8'h00, 0); send(8'h02, 0); send(8'hAA, 0);
    send(8'hBB, 1);
    chk_eq("par_cnt", got_data.size(), 1);
    chk_eq("par_b0", got_data.size() > 0 ? got_data[0] : 8'hxx, 8'hAA);
    chk_eq("par_end", stream_end, 1);
    chk_eq("par_err", err_flag, 1);
    send(8'h4D, 0); send(8'h01, 0);
    chk_eq("par_idle_mode", mode_out, 1);

    // Zero-length burst.
    do_reset();
    got_data.delete();
    send(8'h44, 0); send(8'h00, 0); send(8'h00, 0);
    chk_eq("zlen_err", err_flag, 1);
    send(8'h4D, 0); send(8'h01, 0);
    chk_eq("zlen_idle_mode", mode_out, 1);
    chk_eq("zlen_no_data", got_data.size(), 0);

    // Reset mid-burst drops the remaining length.
    do_reset();
    got_data.delete();
    send(8'h44, 0); send(8'h00, 0); send(8'h05, 0); send(8'hAA, 0);
    do_reset();
    send(8'h4D, 0); send(8'h01, 0);
    chk_eq("rstmid_mode", mode_out, 1);
    chk_eq("rstmid_data", got_data.size(), 1);
    chk_eq("rstmid_err", err_flag, 0);

    // Random command stream with concurrent core -> TX traffic.
    wait_tx_idle();
    do_reset();
    got_data.delete(); exp_data.delete(); got_tx.delete(); exp_tx.delete();
    key_en_cnt = 0; exp_ken = 0;
    exp_key = '0; exp_mode = 0; exp_err = 0; exp_end = 0;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == 8'h06 || b == 8'h15);
      exp_tx.push_back(b);
    end
    foreach (exp_tx[i]) core_q.push_back(exp_tx[i]);
    core_empty = 1'b0;

    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [7:0] b;
      logic pe;
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin
          send(8'h4B, 0);
          for (int i = 0; i < KB; i++) begin
            b = 8'($urandom_range(0, 255));
            pe = ($urandom_range(0, 19) == 0);
            send(b, pe);
            if (pe) begin exp_err = 1; exp_end = 1; break; end
            exp_key[8*(KB-1-i) +: 8] = b;
          end
        end
        1: begin
          b = 8'($urandom_range(0, 255));
          send(8'h4D, 0); send(b, 0);
          exp_mode = b[0];
          exp_ken++;
        end
        2: begin
          logic [15:0] len;
          len = 16'($urandom_range(1, 6));
          send(8'h44, 0); send(len[15:8], 0); send(len[7:0], 0);
          for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom_range(0, 255));
            pe = ($urandom_range(0, 14) == 0);
            send(b, pe);
            if (pe) begin exp_err = 1; exp_end = 1; break; end
            exp_data.push_back(b);
          end
        end
        3: begin send(8'h45, 0); exp_end = 1; end
        4: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h4B || b == 8'h4D || b == 8'h44 || b == 8'h45);
          send(b, 0);
          exp_err = 1;
        end
        5: begin send(8'h44, 0); send(8'h00, 0); send(8'h00, 0); exp_err = 1; end
        default: begin send(8'($urandom_range(0, 255)), 1); exp_err = 1; exp_end = 1; end
      endcase
      chk_eq("rnd_key", key_out, exp_key);
      chk_eq("rnd_mode", mode_out, exp_mode);
      chk_eq("rnd_err", err_flag, exp_err);
      chk_eq("rnd_end", stream_end, exp_end);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    chk_eq("rnd_key_en_cnt", key_en_cnt, exp_ken);
    chk_eq("rnd_data_cnt", got_data.size(), exp_data.size());
    foreach (exp_data[i])
      chk_eq("rnd_data", got_data.size() > i ? got_data[i] : 8'hxx, exp_data[i]);

    ncore = 0;
    for (int c = 0; c < 3000 && ncore < exp_tx.size(); c++) begin
      step();
      ncore = 0;
      foreach (got_tx[i]) if (is_core(got_tx[i])) ncore++;
    end
    chk_eq("tx_cnt", ncore, exp_tx.size());
    begin
      int k = 0;
      foreach (got_tx[i]) begin
        if (is_core(got_tx[i])) begin
          chk_eq("tx_byte", got_tx[i], k < exp_tx.size() ? exp_tx[k] : 8'hxx);
          k++;
        end
      end
    end

`ifdef ECHO_ACK_EN
    // End-of-stream ACK overtakes the waiting core byte.
    wait_tx_idle();
    do_reset();
    got_tx.delete();
    core_q.push_back(8'h3C);
    core_q.push_back(8'hC3);
    core_empty = 1'b0;
    for (int c = 0; c < 200 && got_tx.size() < 1; c++) step();
    send(8'h45, 0);
    for (int c = 0; c < 400 && got_tx.size() < 3; c++) step();
    chk_eq("ack_cnt", got_tx.size(), 3);
    chk_eq("ack_b0", got_tx.size() > 0 ? got_tx[0] : 8'hxx, 8'h3C);
    chk_eq("ack_b1", got_tx.size() > 1 ? got_tx[1] : 8'hxx, 8'h06);
    chk_eq("ack_b2", got_tx.size() > 2 ? got_tx[2] : 8'hxx, 8'hC3);
    chk_eq("ack_end", stream_end, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
